// File: rtl/image_loader.sv
// image_loader: receives an R,G,B byte stream and writes packed {R,G,B}
// pixels row-major into a pixel memory, one write per completed pixel.
// Optional feature: define IMAGE_LOADER_CHECKSUM_EN to add a trailing
// checksum byte (8-bit sum of all bytes plus checksum must be 0 mod 256).
module image_loader #(
    parameter int IMG_W = 192,
    parameter int IMG_H = 108
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        wr_en,
    output logic [14:0] wr_addr,
    output logic [23:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        chk_err
);

    localparam int          NPIX     = IMG_W * IMG_H;
    localparam logic [14:0] LAST_IDX = 15'(NPIX - 1);

    typedef enum logic [2:0] {IDLE, GET_R, GET_G, GET_B, CHK, DONE} state_t;

    state_t      state_q, state_d;
    logic [14:0] pix_q, pix_d;
    logic [7:0]  r_q, r_d, g_q, g_d;
    logic        wr_en_q, wr_en_d;
    logic [14:0] wr_addr_q, wr_addr_d;
    logic [23:0] wr_data_q, wr_data_d;
    logic        accept;

`ifdef IMAGE_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
    logic        chk_err_q, chk_err_d;
`endif

    // Handshake and status are decoded straight from the registered state.
    assign s_ready = (state_q == GET_R) || (state_q == GET_G) ||
                     (state_q == GET_B) || (state_q == CHK);
    // An abort cycle never consumes a byte, even if s_ready is high.
    assign accept  = s_ready && s_valid && !abort;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
`ifdef IMAGE_LOADER_CHECKSUM_EN
    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

    // Next-state, byte capture and pixel write generation.
    always_comb begin
        state_d   = state_q;
        pix_d     = pix_q;
        r_d       = r_q;
        g_d       = g_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef IMAGE_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
        chk_err_d = chk_err_q;
        if (accept && state_q != CHK)
            sum_d = sum_q + s_data;
`endif
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = GET_R;
                    pix_d   = '0;
                    r_d     = '0;
                    g_d     = '0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
                    sum_d     = '0;
                    chk_err_d = 1'b0;
`endif
                end
            end
            GET_R: if (accept) begin
                r_d     = s_data;
                state_d = GET_G;
            end
            GET_G: if (accept) begin
                g_d     = s_data;
                state_d = GET_B;
            end
            GET_B: if (accept) begin
                wr_en_d   = 1'b1;
                wr_addr_d = pix_q;
                wr_data_d = {r_q, g_q, s_data};
                if (pix_q == LAST_IDX) begin
`ifdef IMAGE_LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end else begin
                    pix_d   = pix_q + 15'd1;
                    state_d = GET_R;
                end
            end
            CHK: begin
`ifdef IMAGE_LOADER_CHECKSUM_EN
                if (accept) begin
                    chk_err_d = ((sum_q + s_data) != 8'd0);
                    state_d   = DONE;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort cancels the frame and drops any partially held pixel.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            r_d     = '0;
            g_d     = '0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pix_q     <= '0;
            r_q       <= '0;
            g_q       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
            sum_q     <= '0;
            chk_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pix_q     <= pix_d;
            r_q       <= r_d;
            g_q       <= g_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef IMAGE_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
            chk_err_q <= chk_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// Self-checking bench for image_loader (IMG_W=4, IMG_H=2).
module tb_image_loader;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        reset_n, start, abort, s_valid;
    logic [7:0]  s_data;
    logic        s_ready, wr_en, busy, done, chk_err;
    logic [14:0] wr_addr;
    logic [23:0] wr_data;

    int checks = 0;
    int errs   = 0;

    image_loader #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},   busy,    0);
        chk({tag, "_ready"},  s_ready, 0);
        chk({tag, "_wr_en"},  wr_en,   0);
        chk({tag, "_done"},   done,    0);
    endtask

    // Model: the frame is the list of accepted bytes; pixel k is bytes
    // 3k..3k+2 packed {R,G,B} and must appear on the write port exactly one
    // cycle after its blue byte is taken, at address k.
    task automatic run_frame(input int abort_after, input bit good_sum);
        logic [7:0]  bytes[$];
        logic [7:0]  sum = 8'd0;
        bit          pend = 1'b0;
        logic [14:0] paddr = '0;
        logic [23:0] pdata = '0;
        int          acc = 0;
        int          iter = 0;
        bytes.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        while (acc < NPIX * 3) begin
            if (abort_after >= 0 && acc == abort_after) break;
            if (iter++ > 2000) begin
                chk("frame_timeout", 1, 0);
                break;
            end
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 8'($urandom);
            start   = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            chk("ready", s_ready, 1);
            chk("busy",  busy,    1);
            chk("done_early", done, 0);
            chk("wr_en", wr_en, 32'(pend));
            if (pend) begin
                chk("wr_addr", wr_addr, 32'(paddr));
                chk("wr_data", wr_data, 32'(pdata));
            end
            pend = 1'b0;
            if (s_valid) begin
                bytes.push_back(s_data);
                sum += s_data;
                acc++;
                if (acc % 3 == 0) begin
                    pend  = 1'b1;
                    paddr = 15'(acc / 3 - 1);
                    pdata = {bytes[acc-3], bytes[acc-2], bytes[acc-1]};
                end
            end
            step();
        end
        start   = 1'b0;
        s_valid = 1'b0;
        if (abort_after >= 0) begin
            abort   = 1'b1;
            s_valid = 1'b1;
            s_data  = 8'hAA;
            @(negedge clk);
            chk("abort_wr_en", wr_en, 32'(pend));
            step();
            abort   = 1'b0;
            s_valid = 1'b0;
            @(negedge clk);
            chk_idle("after_abort");
            step();
            chk("abort_no_late_wr", wr_en, 0);
            return;
        end
`ifdef IMAGE_LOADER_CHECKSUM_EN
        s_valid = 1'b1;
        s_data  = good_sum ? (8'd0 - sum) : (8'd1 - sum);
        @(negedge clk);
        chk("chk_ready", s_ready, 1);
        chk("last_wr_en", wr_en, 32'(pend));
        chk("last_wr_addr", wr_addr, 32'(paddr));
        chk("last_wr_data", wr_data, 32'(pdata));
        pend = 1'b0;
        step();
        s_valid = 1'b0;
`endif
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_wr_en", wr_en, 32'(pend));
        if (pend) begin
            chk("last_wr_addr", wr_addr, 32'(paddr));
            chk("last_wr_data", wr_data, 32'(pdata));
        end
`ifdef IMAGE_LOADER_CHECKSUM_EN
        chk("chk_err", chk_err, 32'(!good_sum));
`else
        chk("chk_err", chk_err, 0);
`endif
        step();
        @(negedge clk);
        chk_idle("after_done");
`ifdef IMAGE_LOADER_CHECKSUM_EN
        chk("chk_err_hold", chk_err, 32'(!good_sum));
`else
        chk("chk_err_hold", chk_err, 0);
`endif
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        step();
        step();
        @(negedge clk);
        chk_idle("reset");
        chk("reset_addr", wr_addr, 0);
        chk("reset_data", wr_data, 0);
        chk("reset_chk_err", chk_err, 0);
        step();
        reset_n = 1'b1;
        step();

        // Directed first pixel: 11,22,33 back to back.
        start = 1'b1;
        step();
        start = 1'b0;
        s_valid = 1'b1;
        s_data = 8'h11; step();
        s_data = 8'h22; step();
        s_data = 8'h33;
        @(negedge clk);
        chk("dir_no_wr_yet", wr_en, 0);
        step();
        s_valid = 1'b0;
        @(negedge clk);
        chk("dir_wr_en", wr_en, 1);
        chk("dir_wr_addr", wr_addr, 0);
        chk("dir_wr_data", wr_data, 32'h112233);
        step();
        @(negedge clk);
        chk("dir_wr_one_cycle", wr_en, 0);
        chk("dir_busy", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        chk_idle("dir_abort");
        step();

        // Full random frames, abort after 5 bytes, then restart from 0.
        run_frame(-1, 1'b1);
        run_frame(-1, 1'b1);
        run_frame(5, 1'b1);
        run_frame(-1, 1'b0);

        // Reset mid-frame, then start+abort together while idle.
        start = 1'b1;
        step();
        start = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h5A;
        repeat (4) step();
        reset_n = 1'b0;
        step();
        @(negedge clk);
        chk_idle("mid_reset");
        chk("mid_reset_addr", wr_addr, 0);
        chk("mid_reset_data", wr_data, 0);
        chk("mid_reset_chk_err", chk_err, 0);
        reset_n = 1'b1;
        s_valid = 1'b0;
        start   = 1'b1;
        abort   = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk_idle("start_abort");
        step();
        @(negedge clk);
        chk_idle("start_abort_stay");
        step();

        run_frame(-1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule
